// File: rtl/alu_ctrl_seq.sv
// Registered ALU control sequencer: applies MOV/INC/DEC/address-mode overrides and repeats the code N cycles.
// First ctrl_valid one cycle after accept; a new request is taken only in IDLE or on the final step, with no bubble between them.
module alu_ctrl_seq #(
  parameter int                CTRL_W    = 8,
  parameter int                CNT_W     = 4,
  parameter logic [CTRL_W-1:0] MOV_CODE  = 8'h00,
  parameter logic [CTRL_W-1:0] INC_CODE  = 8'h01,
  parameter logic [CTRL_W-1:0] DEC_CODE  = 8'h02,
  parameter logic [CTRL_W-1:0] ADDR_MASK = 8'h80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              INTERNAL_MOV,
  input  logic              ADDRESS_MODE,
  input  logic              INTERNAL_INC_DEC,
  input  logic              INTERNAL_DEC,
  input  logic [CNT_W-1:0]  rep_cnt,
  input  logic              abort,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              ctrl_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CTRL_W-1:0] code_q, code_d;

  logic [CTRL_W-1:0] sel_code;
  logic [CNT_W-1:0]  sel_n;
  logic              run;
  logic              last;
  logic              accept;

  // INC/DEC outranks MOV; the address modifier applies to whichever code won.
  always_comb begin
    sel_code = ctrl_in;
    sel_n    = CNT_W'(1);
    if (!INTERNAL_INC_DEC) begin
      sel_code = INTERNAL_DEC ? INC_CODE : DEC_CODE;
      sel_n    = (rep_cnt == '0) ? CNT_W'(1) : rep_cnt;
    end else if (!INTERNAL_MOV) begin
      sel_code = MOV_CODE;
    end
    if (!ADDRESS_MODE) begin
      sel_code = sel_code | ADDR_MASK;
    end
  end

  assign run        = (state_q == RUN);
  assign last       = (remaining_q == CNT_W'(1));
  assign req_ready  = rst_n && (!run || (last && !abort));
  assign accept     = req_valid && req_ready;
  assign ctrl_valid = run;
  assign busy       = run;
  assign done       = run && last && !abort;
  assign ctrl_out   = run ? code_q : '0;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    code_d      = code_q;
    if (run && abort) begin
      state_d     = IDLE;
      remaining_d = '0;
    end else if (accept) begin
      state_d     = RUN;
      remaining_d = sel_n;
      code_d      = sel_code;
    end else if (run && last) begin
      state_d     = IDLE;
      remaining_d = '0;
    end else if (run) begin
      remaining_d = remaining_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      code_q      <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      code_q      <= code_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: vector table plus hand sequences, expected steps queued at accept and checked on negedge.
module tb_alu_ctrl_seq;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] ctrl_in;
  logic       INTERNAL_MOV;
  logic       ADDRESS_MODE;
  logic       INTERNAL_INC_DEC;
  logic       INTERNAL_DEC;
  logic [3:0] rep_cnt;
  logic       abort;
  logic [7:0] ctrl_out;
  logic       ctrl_valid;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] code;
    logic       last;
  } exp_t;

  typedef struct packed {
    logic [7:0] ctrl;
    logic       mov;
    logic       amode;
    logic       incdec;
    logic       dec;
    logic [3:0] rep;
    logic [7:0] code;
    logic [4:0] n;
  } vec_t;

  exp_t q[$];
  vec_t vecs[9];

  alu_ctrl_seq dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .ctrl_in          (ctrl_in),
    .INTERNAL_MOV     (INTERNAL_MOV),
    .ADDRESS_MODE     (ADDRESS_MODE),
    .INTERNAL_INC_DEC (INTERNAL_INC_DEC),
    .INTERNAL_DEC     (INTERNAL_DEC),
    .rep_cnt          (rep_cnt),
    .abort            (abort),
    .ctrl_out         (ctrl_out),
    .ctrl_valid       (ctrl_valid),
    .busy             (busy),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle with a queued step must show that step; otherwise the outputs must be idle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("step_valid", {31'b0, ctrl_valid}, 32'd1);
      chk("step_code", {24'b0, ctrl_out}, {24'b0, e.code});
      chk("step_busy", {31'b0, busy}, 32'd1);
      chk("step_done", {31'b0, done}, {31'b0, e.last});
      chk("step_ready", {31'b0, req_ready}, {31'b0, e.last});
    end else begin
      chk("idle_valid", {31'b0, ctrl_valid}, 32'd0);
      chk("idle_code", {24'b0, ctrl_out}, 32'd0);
      chk("idle_busy", {31'b0, busy}, 32'd0);
      chk("idle_done", {31'b0, done}, 32'd0);
    end
  end

  task automatic drive_req(input logic [7:0] c, input logic mov, input logic amode,
                           input logic incdec, input logic dec, input logic [3:0] rep);
    ctrl_in          = c;
    INTERNAL_MOV     = mov;
    ADDRESS_MODE     = amode;
    INTERNAL_INC_DEC = incdec;
    INTERNAL_DEC     = dec;
    rep_cnt          = rep;
    req_valid        = 1'b1;
  endtask

  task automatic idle_inputs();
    req_valid        = 1'b0;
    ctrl_in          = 8'hC3;
    INTERNAL_MOV     = 1'b1;
    ADDRESS_MODE     = 1'b1;
    INTERNAL_INC_DEC = 1'b1;
    INTERNAL_DEC     = 1'b1;
    rep_cnt          = 4'd9;
  endtask

  task automatic push_steps(input logic [7:0] code, input int n, input logic last_flag);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.code = code;
      e.last = (i == n - 1) ? last_flag : 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_timeout", {31'b0, (q.size() != 0)}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    idle_inputs();
    abort = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'b0, ctrl_valid}, 32'd0);
    chk("rst_code", {24'b0, ctrl_out}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    //          ctrl   mov   amode incdec dec   rep    code   n
    vecs[0] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  8'h5A, 5'd1};
    vecs[1] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  8'h80, 5'd1};
    vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0,  8'h00, 5'd1};
    vecs[3] = '{8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3,  8'h01, 5'd3};
    vecs[4] = '{8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  8'h02, 5'd1};
    vecs[5] = '{8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 8'h02, 5'd15};
    vecs[6] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7,  8'h3C, 5'd1};
    vecs[7] = '{8'h10, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2,  8'h81, 5'd2};
    vecs[8] = '{8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5,  8'h00, 5'd1};

    for (int v = 0; v < 9; v++) begin
      chk("vec_ready", {31'b0, req_ready}, 32'd1);
      drive_req(vecs[v].ctrl, vecs[v].mov, vecs[v].amode, vecs[v].incdec, vecs[v].dec, vecs[v].rep);
      @(posedge clk); #1;
      idle_inputs();
      push_steps(vecs[v].code, int'(vecs[v].n), 1'b1);
      drain();
    end

    // Abort on step 2 of a 4-step DEC: two valid cycles, no done.
    drive_req(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4);
    @(posedge clk); #1;
    idle_inputs();
    push_steps(8'h02, 2, 1'b0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    drain();

    // Abort on the final step wins over both done and a pending request.
    drive_req(8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2);
    @(posedge clk); #1;
    idle_inputs();
    push_steps(8'h01, 2, 1'b0);
    @(posedge clk); #1;
    abort = 1'b1;
    drive_req(8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    idle_inputs();
    drain();

    // Abort while idle does not block acceptance.
    abort = 1'b1;
    drive_req(8'h6E, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    idle_inputs();
    push_steps(8'h6E, 1, 1'b1);
    drain();

    // Back-to-back: request held from step 1 is taken on the final step with no gap.
    drive_req(8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2);
    @(posedge clk); #1;
    push_steps(8'h01, 2, 1'b1);
    drive_req(8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    idle_inputs();
    push_steps(8'h33, 1, 1'b1);
    drain();

    // Reset in the middle of a 5-step INC clears outputs at once.
    drive_req(8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5);
    @(posedge clk); #1;
    idle_inputs();
    push_steps(8'h01, 5, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_valid", {31'b0, ctrl_valid}, 32'd0);
    chk("mid_rst_code", {24'b0, ctrl_out}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    drive_req(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3);
    @(posedge clk); #1;
    idle_inputs();
    push_steps(8'hA5, 1, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
